// File: rtl/bcd_seg_scanner.sv
// Three-digit common-anode scanner for a 9-bit BCD word, with per-slot blanking and updates that only take effect at a frame boundary.
// Optional build macro LEADING_ZERO_BLANK_EN suppresses leading-zero hundreds/tens segments.
module bcd_seg_scanner #(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [8:0] bcd_in,
  input  logic       load,
  output logic [6:0] seg_n,
  output logic [2:0] an_n,
  output logic       upd_pend
);

  localparam int TW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [TW-1:0] TICK_MAX  = TW'(REFRESH_DIV - 1);
  localparam logic [TW-1:0] BLANK_END = TW'(BLANK_CYCLES);

  typedef enum logic [1:0] {S_ONES = 2'd0, S_TENS = 2'd1, S_HUND = 2'd2} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [TW-1:0]   r_tick;
  logic [8:0]      r_active;
  logic [8:0]      r_pending;
  logic            r_upd_pend;
  logic [6:0]      r_seg_n;
  logic [2:0]      r_an_n;
  logic            w_wrap;
  logic            w_frame_end;
  logic [3:0]      w_digit;
  logic [2:0]      w_slot_an;
  logic            w_lz_blank;
  logic [6:0]      w_seg_nxt;
  logic [2:0]      w_an_nxt;

  function automatic logic [6:0] f_decode(input logic [3:0] d);
    case (d)
      4'd0:    f_decode = 7'h40;
      4'd1:    f_decode = 7'h79;
      4'd2:    f_decode = 7'h24;
      4'd3:    f_decode = 7'h30;
      4'd4:    f_decode = 7'h19;
      4'd5:    f_decode = 7'h12;
      4'd6:    f_decode = 7'h02;
      4'd7:    f_decode = 7'h78;
      4'd8:    f_decode = 7'h00;
      4'd9:    f_decode = 7'h10;
      default: f_decode = 7'h3F;
    endcase
  endfunction

  assign w_wrap      = (r_tick == TICK_MAX);
  assign w_frame_end = w_wrap && (r_state == S_HUND);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tick <= '0;
    end else if (w_wrap) begin
      r_tick <= '0;
    end else begin
      r_tick <= r_tick + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_ONES;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_wrap) begin
      case (r_state)
        S_ONES:  w_state_nxt = S_TENS;
        S_TENS:  w_state_nxt = S_HUND;
        default: w_state_nxt = S_ONES;
      endcase
    end
  end

  // A load landing on the boundary cycle bypasses pending so it is never a frame late.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_active   <= '0;
      r_pending  <= '0;
      r_upd_pend <= 1'b0;
    end else if (load && w_frame_end) begin
      r_active   <= bcd_in;
      r_pending  <= bcd_in;
      r_upd_pend <= 1'b0;
    end else if (w_frame_end && r_upd_pend) begin
      r_active   <= r_pending;
      r_upd_pend <= 1'b0;
    end else if (load) begin
      r_pending  <= bcd_in;
      r_upd_pend <= 1'b1;
    end
  end

  always_comb begin
    w_digit   = r_active[3:0];
    w_slot_an = 3'b110;
    case (r_state)
      S_TENS: begin
        w_digit   = r_active[7:4];
        w_slot_an = 3'b101;
      end
      S_HUND: begin
        w_digit   = {3'b000, r_active[8]};
        w_slot_an = 3'b011;
      end
      default: ;
    endcase
  end

`ifdef LEADING_ZERO_BLANK_EN
  assign w_lz_blank = ((r_state == S_HUND) && !r_active[8]) ||
                      ((r_state == S_TENS) && !r_active[8] && (r_active[7:4] == 4'd0));
`else
  assign w_lz_blank = 1'b0;
`endif

  always_comb begin
    w_an_nxt  = 3'b111;
    w_seg_nxt = 7'h7F;
    if (r_tick >= BLANK_END) begin
      w_an_nxt  = w_slot_an;
      w_seg_nxt = w_lz_blank ? 7'h7F : f_decode(w_digit);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_seg_n <= 7'h7F;
      r_an_n  <= 3'b111;
    end else begin
      r_seg_n <= w_seg_nxt;
      r_an_n  <= w_an_nxt;
    end
  end

  assign seg_n    = r_seg_n;
  assign an_n     = r_an_n;
  assign upd_pend = r_upd_pend;

endmodule

// File: tb/tb_bcd_seg_scanner.sv
// Self-checking bench for bcd_seg_scanner: scoreboarded frame contents, slot timing, load/update rules.
module tb_bcd_seg_scanner;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [8:0] bcd_in = '0;
  logic       load = 1'b0;
  logic [6:0] seg_n;
  logic [2:0] an_n;
  logic       upd_pend;

  int n_cmp = 0;
  int n_bad = 0;
  int pos   = -1;
  logic [9:0] sb[$];

  bcd_seg_scanner #(.REFRESH_DIV(8), .BLANK_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .bcd_in(bcd_in), .load(load),
    .seg_n(seg_n), .an_n(an_n), .upd_pend(upd_pend)
  );

  always #5 clk = ~clk;

  // After a step, outputs reflect frame position pos (0..23 within a frame).
  task automatic step();
    @(posedge clk);
    pos++;
    #1;
  endtask

  function automatic int fpos();
    return (pos + 24) % 24;
  endfunction

  task automatic goto(input int p);
    for (int i = 0; i < 30 && fpos() != p; i++) step();
  endtask

  task automatic pulse_load(input logic [8:0] v);
    bcd_in = v;
    load   = 1'b1;
    step();
    load   = 1'b0;
  endtask

  function automatic logic [6:0] ref_dec(input logic [3:0] d);
    logic [6:0] tbl [0:9];
    tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    return (d > 4'd9) ? 7'h3F : tbl[d];
  endfunction

  function automatic logic [9:0] ref_slot(input int s, input logic [8:0] v);
    logic [3:0] d;
    logic [6:0] sg;
    logic [2:0] an;
    d  = (s == 0) ? v[3:0] : (s == 1) ? v[7:4] : {3'b000, v[8]};
    an = (s == 0) ? 3'b110 : (s == 1) ? 3'b101 : 3'b011;
    sg = ref_dec(d);
`ifdef LEADING_ZERO_BLANK_EN
    if (s == 2 && !v[8]) sg = 7'h7F;
    if (s == 1 && !v[8] && v[7:4] == 4'd0) sg = 7'h7F;
`endif
    return {an, sg};
  endfunction

  task automatic push_frame(input logic [8:0] v);
    for (int s = 0; s < 3; s++) sb.push_back(ref_slot(s, v));
  endtask

  // Walks one full frame from its first cycle: 2 blank cycles then 6 lit cycles per slot.
  task automatic run_frame(input string tag);
    logic [9:0] e;
    logic [9:0] w;
    goto(23);
    for (int s = 0; s < 3; s++) begin
      if (sb.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL %s: scoreboard empty at slot %0d", tag, s);
        e = 10'h3FF;
      end else begin
        e = sb.pop_front();
      end
      for (int k = 0; k < 8; k++) begin
        step();
        w = (k < 2) ? {3'b111, 7'h7F} : e;
        n_cmp++;
        if ({an_n, seg_n} !== w) begin
          n_bad++;
          $display("FAIL %s slot%0d cyc%0d: got an_n=%b seg_n=%h, want an_n=%b seg_n=%h",
                   tag, s, k, an_n, seg_n, w[9:7], w[6:0]);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if (seg_n !== 7'h7F || an_n !== 3'b111 || upd_pend !== 1'b0) begin
        n_bad++;
        $display("FAIL reset cyc%0d: got seg_n=%h an_n=%b upd_pend=%b, want 7f 111 0",
                 i, seg_n, an_n, upd_pend);
      end
    end
    rst_n = 1'b1;
    pos   = -1;
    push_frame(9'h000);
    run_frame("reset_first_frame");
  endtask

  task automatic test_reset_mid_frame();
    goto(5);
    pulse_load(9'h155);
    n_cmp++;
    if (upd_pend !== 1'b1) begin
      n_bad++;
      $display("FAIL midreset_pend_set: got upd_pend=%b, want 1", upd_pend);
    end
    rst_n = 1'b0;
    step();
    n_cmp++;
    if (upd_pend !== 1'b0 || an_n !== 3'b111 || seg_n !== 7'h7F) begin
      n_bad++;
      $display("FAIL midreset_clear: got upd_pend=%b an_n=%b seg_n=%h, want 0 111 7f",
               upd_pend, an_n, seg_n);
    end
    rst_n = 1'b1;
    pos   = -1;
    push_frame(9'h000);
    run_frame("midreset_frame");
  endtask

  task automatic test_load_mid_tens();
    goto(11);
    pulse_load(9'h127);
    push_frame(9'h127);
    n_cmp++;
    if (upd_pend !== 1'b1) begin
      n_bad++;
      $display("FAIL tens_load_pend: got upd_pend=%b, want 1", upd_pend);
    end
    goto(22);
    n_cmp++;
    if (upd_pend !== 1'b1) begin
      n_bad++;
      $display("FAIL tens_pend_hold: got upd_pend=%b, want 1", upd_pend);
    end
    step();
    n_cmp++;
    if (upd_pend !== 1'b0) begin
      n_bad++;
      $display("FAIL tens_pend_clear: got upd_pend=%b, want 0", upd_pend);
    end
    run_frame("load_127");
  endtask

  task automatic test_invalid_digit();
    goto(4);
    pulse_load(9'h03A);
    push_frame(9'h03A);
    run_frame("invalid_03A");
  endtask

  task automatic test_load_on_boundary();
    goto(22);
    pulse_load(9'h199);
    push_frame(9'h199);
    n_cmp++;
    if (upd_pend !== 1'b0) begin
      n_bad++;
      $display("FAIL boundary_no_pend: got upd_pend=%b, want 0", upd_pend);
    end
    run_frame("boundary_199");
  endtask

  task automatic test_back_to_back();
    goto(1);
    pulse_load(9'h042);
    goto(9);
    pulse_load(9'h088);
    push_frame(9'h088);
    n_cmp++;
    if (upd_pend !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_pend: got upd_pend=%b, want 1", upd_pend);
    end
    run_frame("b2b_088");
  endtask

  task automatic test_leading_zero();
    goto(14);
    pulse_load(9'h005);
    push_frame(9'h005);
    run_frame("lz_005");
    n_cmp++;
    if (upd_pend !== 1'b0) begin
      n_bad++;
      $display("FAIL lz_pend: got upd_pend=%b, want 0", upd_pend);
    end
  endtask

  initial begin
    test_reset();
    test_load_mid_tens();
    test_invalid_digit();
    test_load_on_boundary();
    test_back_to_back();
    test_leading_zero();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
